// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: state sequencer, datapath control decode
// and a retired-instruction counter.
module multicycle_control #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [1:0]         alu_op,
    output logic [3:0]         state,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t             r_state;
    state_t             w_next;
    logic [COUNT_W-1:0] r_count;
    logic               w_retire;

    logic       w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write;
    logic       w_ir_write, w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a;
    logic       w_illegal;
    logic [1:0] w_alu_src_b, w_pc_source, w_alu_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_comb begin
        w_next          = S_FETCH;
        w_retire        = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_pc_source     = 2'b00;
        w_alu_op        = 2'b00;
        w_illegal       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = mem_ready;
                w_pc_write  = mem_ready;
                w_next      = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU precomputes PC + (sign-extended imm << 2) for a possible branch.
                w_alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                w_next     = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                w_retire    = mem_ready;
                w_next      = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_retire    = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_retire        = 1'b1;
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
                w_retire    = 1'b1;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Write enables are masked by rst directly so FETCH cannot strobe while held in reset.
    assign pc_write      = w_pc_write & ~rst;
    assign pc_write_cond = w_pc_write_cond & ~rst;
    assign ir_write      = w_ir_write & ~rst;
    assign mem_write     = w_mem_write & ~rst;
    assign reg_write     = w_reg_write & ~rst;
    assign illegal_op    = w_illegal & ~rst;
    assign i_or_d        = w_i_or_d;
    assign mem_read      = w_mem_read;
    assign reg_dst       = w_reg_dst;
    assign mem_to_reg    = w_mem_to_reg;
    assign alu_src_a     = w_alu_src_a;
    assign alu_src_b     = w_alu_src_b;
    assign pc_source     = w_pc_source;
    assign alu_op        = w_alu_op;
    assign state         = r_state;
    assign instr_count   = r_count;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: COUNT_W, 16, width of the retired-instruction counter.
REQ-002 Port: clk, in, 1, single clock; all state updates on the rising edge.
REQ-003 Port: rst, in, 1, reset, asynchronous and active-high.
REQ-004 Port: opcode, in, 6, instruction bits [31:26], sampled from the instruction register.
REQ-005 Port: mem_ready, in, 1, memory handshake; high = access completes this cycle.
REQ-006 Port: pc_write / pc_write_cond, out, 1 each, unconditional / branch-qualified PC write enables.
REQ-007 Port: i_or_d, mem_read, mem_write, ir_write, out, 1 each, memory address select (1 = ALUOut) and access strobes.
REQ-008 Port: reg_dst, mem_to_reg, reg_write, alu_src_a, out, 1 each, register-file and ALU A-mux controls.
REQ-009 Port: alu_src_b, pc_source, alu_op, out, 2 each; alu_op feeds the ALUControl 2-bit opcode input (00 add, 01 sub, 10 funct-decoded).
REQ-010 Port: state, out, 4, current state encoding for debug.
REQ-011 Port: illegal_op, out, 1, one-cycle pulse on an unsupported opcode.
REQ-012 Port: instr_count, out, COUNT_W, count of retired instructions.

Function
REQ-013 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 return to FETCH on the next edge.
REQ-014 FETCH outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
REQ-015 FETCH handshake: ir_write=1 and pc_write=1 only while mem_ready=1; stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-016 DECODE outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
REQ-017 DECODE next state by opcode: 0x23 or 0x2B to MEMADR; 0x00 to EXEC; 0x04 to BRANCH; 0x02 to JUMP; 0x08 to ADDIEX.
REQ-018 DECODE, any other opcode: illegal_op=1 for that cycle, next state FETCH, instr_count unchanged.
REQ-019 MEMADR outputs: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEMRD if opcode=0x23, else MEMWR.
REQ-020 MEMRD: mem_read=1, i_or_d=1; hold while mem_ready=0; go to MEMWB when mem_ready=1.
REQ-021 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next state FETCH.
REQ-022 MEMWR: mem_write=1, i_or_d=1; hold while mem_ready=0; go to FETCH when mem_ready=1.
REQ-023 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next state RTYPEWB.
REQ-024 RTYPEWB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; next state FETCH.
REQ-026 JUMP: pc_write=1, pc_source=10; next state FETCH.
REQ-027 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; next state ADDIWB.
REQ-028 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
REQ-029 Every control output not listed for a state is 0 in that state.
REQ-030 instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, RTYPEWB, BRANCH, JUMP or ADDIWB; it wraps from all-ones to 0.
REQ-031 Cycles per instruction with mem_ready held high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-032 While rst=1: state=FETCH, instr_count=0, illegal_op=0, and all write enables (pc_write, pc_write_cond, ir_write, mem_write, reg_write) forced to 0 regardless of mem_ready.
REQ-033 rst asserted mid-instruction (any state) takes effect immediately; after release the first edge evaluates FETCH.

Verification
REQ-034 rst pulse, then opcode=0x00, mem_ready=1: states 0,1,6,7,0; alu_op=10 in EXEC; reg_write=1 with reg_dst=1 in RTYPEWB; instr_count=1.
REQ-035 opcode=0x23, mem_ready=0 for 3 cycles in MEMRD: state holds at 3 for 3 cycles, then 4; mem_write=0 throughout; instr_count increments once.
REQ-036 opcode=0x04: BRANCH asserts alu_op=01, pc_write_cond=1, pc_source=01; total 3 cycles; then opcode=0x02: JUMP asserts pc_write=1, pc_source=10.
REQ-037 opcode=0x3F: illegal_op=1 for exactly one cycle in DECODE, then FETCH; instr_count unchanged.
REQ-038 Preload 2^COUNT_W-1 retirements, then complete one addi (0x08): instr_count wraps to 0.
REQ-039 Assert rst during MEMWR with mem_ready=0: state=0 and mem_write=0 within the same cycle; instr_count=0.
